muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle RV32M/RV64M multiply/divide unit, parametrised in XLEN. Sits in EX beside the combinational ALU and takes OP_R3 instructions with funct_7 = M. Uses a valid/ready handshake on both sides so the hazard unit can stall the pipeline while the unit is busy. A flush input drops an in-flight operation on a branch/jump redirect.

Parameters:
XLEN, 32, operand/result width in bits (32 or 64)
TAG_W, 5, width of the destination-register tag carried alongside the operation

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  1  operation request from EX
in_ready  output  1  unit can accept; equals (state==IDLE)
funct_3  input  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
in1  input  XLEN  rs1 value
in2  input  XLEN  rs2 value
tag_in  input  TAG_W  rd index, returned unchanged with the result
flush  input  1  synchronous kill of any accepted or in-flight op
out_valid  output  1  result available
out_ready  input  1  writeback consumes the result
out  output  XLEN  result
tag_out  output  TAG_W  rd index of the result

Behaviour:
- States: IDLE, BUSY, DONE. Reset values: state=IDLE, out_valid=0, out=0, tag_out=0, step counter=0. in_ready=1 during reset.
- Accept: in_valid && in_ready at a clock edge. On accept, latch funct_3, tag, and operand magnitudes plus sign flags. The sign rules are: MUL/MULH treat both operands as signed; MULHSU treats in1 as signed and in2 as unsigned; MULHU/DIVU/REMU treat both as unsigned; DIV/REM treat both as signed.
- Fast path on accept, going IDLE->DONE in one edge:
  - DIV/DIVU with in2==0 gives all ones.
  - REM/REMU with in2==0 gives in1.
  - DIV with in1==-2^(XLEN-1) and in2==-1 gives -2^(XLEN-1).
  - REM with the same operands gives 0.
- Otherwise IDLE->BUSY with counter=XLEN.
- BUSY: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter decrements each step. On the edge where the counter reaches 0, go to DONE. Sign correction and result select are registered into out on that edge.
- Result select:
  - MUL gives the low XLEN bits of the product; MULH/MULHSU/MULHU give the high XLEN bits.
  - DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Product is negated if the operand signs differ (signed cases). Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
- Latency: iterative op, out_valid first high XLEN+1 cycles after the accept cycle (33 for XLEN=32). Fast path: 1 cycle.
- DONE: out_valid=1. out and tag_out are held stable until out_ready=1. On that edge go to DONE->IDLE and out_valid drops. No new accept while in DONE; in_ready=0.
- flush: at the next edge the state goes to IDLE and out_valid=0, from any state. flush has priority over accept and over out_ready in the same cycle. out keeps its last value, which is don't-care.
- reset mid-operation: all state cleared asynchronously; no result is produced.
- Widths: all arithmetic is unsigned on magnitudes. The most-negative operand magnitude is 2^(XLEN-1) and must not overflow, so the internal magnitude registers are XLEN bits unsigned.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU are computed by a single-cycle signed 2*XLEN multiply on accept and go IDLE->DONE, giving latency 1. Divides are unchanged.
- Undefined: all multiplies use the iterative XLEN-step path. The result values are identical in both cases.

Test Plan:
1. XLEN=32, MUL in1=7, in2=0xFFFFFFFD (-3), tag 5 -> out=0xFFFFFFEB, tag_out=5. out_valid exactly 33 cycles after accept, or 1 cycle with MULDIV_FAST_MUL_EN.
2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; REM 7/-2 -> 1.
4. Special cases, each with latency 1:
   - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out, tag_out stable and in_ready=0 throughout. Then out_ready=1 -> IDLE at the next edge; a new in_valid is accepted the cycle after.
6. Kill cases:
   - flush asserted on the 10th BUSY cycle of a DIV -> no out_valid, in_ready=1 next cycle.
   - flush and in_valid in the same IDLE cycle -> op not accepted.
   - reset pulsed mid-MUL -> out_valid=0 and out=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshake on both sides.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle on accept.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct_3,
    input  logic [XLEN-1:0]  in1,
    input  logic [XLEN-1:0]  in2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   b_mag;
    logic              res_neg;
    logic              rem_neg;
    logic [CNT_W-1:0]  count;
    // Low half holds the multiplier / dividend, high half the partial product / remainder.
    logic [2*XLEN-1:0] acc;

    logic              a_sgn;
    logic              b_sgn;
    logic              a_neg_in;
    logic              b_neg_in;
    logic [XLEN-1:0]   a_mag_in;
    logic [XLEN-1:0]   b_mag_in;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_val;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   res_val;

    function automatic logic [XLEN-1:0] select_mul(input logic [2:0] f,
                                                   input logic [2*XLEN-1:0] p);
        return (f == F_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign in_ready = (state == IDLE);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct_3)
            F_MUL, F_MULH, F_DIV, F_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            F_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
    end

    // Magnitudes stay XLEN bits unsigned: the most-negative value maps to 2^(XLEN-1) exactly.
    assign a_neg_in = a_sgn & in1[XLEN-1];
    assign b_neg_in = b_sgn & in2[XLEN-1];
    assign a_mag_in = a_neg_in ? -in1 : in1;
    assign b_mag_in = b_neg_in ? -in2 : in2;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] fast_prod;

    // Low 2*XLEN bits of the sign-extended product equal the signed product.
    assign a_ext     = {{XLEN{a_neg_in}}, in1};
    assign b_ext     = {{XLEN{b_neg_in}}, in2};
    assign fast_prod = a_ext * b_ext;
`endif

    always_comb begin
        fast_hit = 1'b0;
        fast_val = '0;
        if (funct_3[2]) begin
            if (in2 == '0) begin
                fast_hit = 1'b1;
                fast_val = funct_3[1] ? in1 : '1;
            end else if (!funct_3[0] && in1 == MOST_NEG && in2 == '1) begin
                fast_hit = 1'b1;
                fast_val = funct_3[1] ? '0 : MOST_NEG;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        else begin
            fast_hit = 1'b1;
            fast_val = select_mul(funct_3, fast_prod);
        end
`endif
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, b_mag};
        if (!op_q[2]) begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = res_neg ? -acc_step : acc_step;
        quot_fix = res_neg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_fix  = rem_neg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (op_q)
            F_DIV, F_DIVU: res_val = quot_fix;
            F_REM, F_REMU: res_val = rem_fix;
            default:       res_val = select_mul(op_q, prod_fix);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            tag_out   <= '0;
            count     <= '0;
            op_q      <= '0;
            b_mag     <= '0;
            acc       <= '0;
            res_neg   <= 1'b0;
            rem_neg   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= funct_3;
                        tag_out <= tag_in;
                        b_mag   <= b_mag_in;
                        acc     <= {{XLEN{1'b0}}, a_mag_in};
                        res_neg <= a_neg_in ^ b_neg_in;
                        rem_neg <= a_neg_in;
                        if (fast_hit) begin
                            out       <= fast_val;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            count <= CNT_W'(XLEN);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_step;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        out       <= res_val;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed plan cases, random ops vs an
// arithmetic reference model, backpressure, flush and asynchronous reset.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct_3;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  tag_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [4:0]  tag_out;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct_3   (funct_3),
        .in1       (in1),
        .in2       (in2),
        .tag_in    (tag_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .tag_out   (tag_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the RISC-V M-extension rules.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f)
            3'd0: begin p = sa * sb;           return p[31:0];  end
            3'd1: begin p = sa * sb;           return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin pu = ua * ub;          return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                pu = ua / ub;
                return pu[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                pu = ua % ub;
                return pu[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Called just after the accept edge; lat counts cycles from the accept cycle.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tg, input string name, output logic [31:0] res);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        funct_3  = f;
        in1      = a;
        in2      = b;
        tag_in   = tg;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        res = out;
        check({name, "_val"}, 64'(out), 64'(model(f, a, b)));
        check({name, "_tag"}, 64'(tag_out), 64'(tg));
        check({name, "_lat"}, 64'(lat), 64'(exp_lat(f, a, b)));
        drain();
        check({name, "_release"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        logic [31:0] res;
        logic [2:0]  rf;
        int          lat;
        logic        seen;

        reset     = 1'b0;
        in_valid  = 1'b0;
        funct_3   = '0;
        in1       = '0;
        in2       = '0;
        tag_in    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({in_ready, out_valid, out, tag_out}), 64'({1'b1, 1'b0, 32'h0, 5'h0}));
        @(negedge clk);
        reset = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul_7_m3", res);
        check("tp_mul_7_m3", 64'(res), 64'(32'hFFFF_FFEB));
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, "mulh_min", res);
        check("tp_mulh_min", 64'(res), 64'(32'h4000_0000));
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhu_ones", res);
        check("tp_mulhu_ones", 64'(res), 64'(32'hFFFF_FFFE));
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhsu_ones", res);
        check("tp_mulhsu_ones", 64'(res), 64'(32'hFFFF_FFFF));
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, "mul_ones", res);
        check("tp_mul_ones", 64'(res), 64'(32'h0000_0001));
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, "div_m7_2", res);
        check("tp_div_m7_2", 64'(res), 64'(32'hFFFF_FFFD));
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, "rem_m7_2", res);
        check("tp_rem_m7_2", 64'(res), 64'(32'hFFFF_FFFF));
        run_op(3'd5, 32'd100, 32'd7, 5'd8, "divu_100_7", res);
        check("tp_divu_100_7", 64'(res), 64'(32'd14));
        run_op(3'd7, 32'd100, 32'd7, 5'd9, "remu_100_7", res);
        check("tp_remu_100_7", 64'(res), 64'(32'd2));
        run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd10, "rem_7_m2", res);
        check("tp_rem_7_m2", 64'(res), 64'(32'd1));
        run_op(3'd4, 32'd5, 32'd0, 5'd11, "div_by0", res);
        check("tp_div_by0", 64'(res), 64'(32'hFFFF_FFFF));
        run_op(3'd7, 32'd5, 32'd0, 5'd12, "remu_by0", res);
        check("tp_remu_by0", 64'(res), 64'(32'd5));
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, "div_ovf", res);
        check("tp_div_ovf", 64'(res), 64'(32'h8000_0000));
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, "rem_ovf", res);
        check("tp_rem_ovf", 64'(res), 64'(32'h0));

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            run_op(rf, pick(), pick(), 5'($urandom_range(0, 31)), "rnd", res);
        end

        // Backpressure: result held for 10 cycles while a new request waits.
        @(negedge clk);
        in_valid = 1'b1;
        funct_3  = 3'd5;
        in1      = 32'd100;
        in2      = 32'd7;
        tag_in   = 5'd9;
        @(posedge clk);
        #1;
        funct_3  = 3'd0;
        in1      = 32'd3;
        in2      = 32'd4;
        tag_in   = 5'd2;
        wait_valid(lat);
        check("bp_first_lat", 64'(lat), 64'(33));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", 64'({out_valid, in_ready, tag_out, out}), 64'({1'b1, 1'b0, 5'd9, 32'd14}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_to_idle", 64'({out_valid, in_ready}), 64'(2'b01));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_accept", 64'(in_ready), 64'(0));
        wait_valid(lat);
        check("bp_next_val", 64'({out_valid, tag_out, out}), 64'({1'b1, 5'd2, 32'd12}));
        drain();

        // Flush on the 10th BUSY cycle of a divide.
        @(negedge clk);
        in_valid = 1'b1;
        funct_3  = 3'd4;
        in1      = 32'd1000;
        in2      = 32'd3;
        tag_in   = 5'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'({out_valid, in_ready}), 64'(2'b01));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        check("flush_no_result", 64'(seen), 64'(0));

        // Flush together with a request in IDLE: the request is dropped.
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        funct_3  = 3'd0;
        in1      = 32'd2;
        in2      = 32'd3;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_accept", 64'({out_valid, in_ready}), 64'(2'b01));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        check("flush_accept_none", 64'(seen), 64'(0));

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1;
        funct_3  = 3'd0;
        in1      = 32'd7;
        in2      = 32'd9;
        tag_in   = 5'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset_async", 64'({out_valid, in_ready, tag_out, out}), 64'({1'b0, 1'b1, 5'd0, 32'd0}));
        #1 reset = 1'b0;

        run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd17, "post_reset", res);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
